// File: rtl/pll_pkg.sv
// Shared types and helpers for the rational-rate clock-enable generator.
package pll_pkg;

  localparam int unsigned ACC_W_DEF       = 16;
  localparam int unsigned LOCK_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    RESET   = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } pll_state_t;

  // A ratio above one cannot be produced, so the numerator saturates at the denominator.
  function automatic logic [31:0] clamp_num(input logic [31:0] num, input logic [31:0] den);
    return (num > den) ? den : num;
  endfunction

endpackage

// File: rtl/frac_clken.sv
// One fractional clock-enable channel: num/den registers and a phase accumulator.
module frac_clken
  import pll_pkg::*;
#(
  parameter int unsigned       ACC_W   = ACC_W_DEF,
  parameter logic [ACC_W-1:0]  DEF_NUM = ACC_W'(1),
  parameter logic [ACC_W-1:0]  DEF_DEN = ACC_W'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_num,
  input  logic [ACC_W-1:0] wr_den,
  input  logic             clr,
  input  logic             run,
  output logic             pulse_c
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] num_q, num_d;
  logic [ACC_W-1:0] den_q, den_d;
  logic [ACC_W:0]   sum_c;

  always_comb begin
    num_d   = num_q;
    den_d   = den_q;
    acc_d   = acc_q;
    pulse_c = 1'b0;
    sum_c   = {1'b0, acc_q} + {1'b0, num_q};
    if (wr_en) begin
      num_d = ACC_W'(clamp_num(32'(wr_num), 32'(wr_den)));
      den_d = wr_den;
    end
    if (clr) begin
      acc_d = '0;
    end else if (run) begin
      // A zero denominator parks the channel with no pulses.
      if (den_q == '0) begin
        acc_d = '0;
      end else if (sum_c >= {1'b0, den_q}) begin
        acc_d   = ACC_W'(sum_c - {1'b0, den_q});
        pulse_c = 1'b1;
      end else begin
        acc_d = ACC_W'(sum_c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      num_q <= DEF_NUM;
      den_q <= DEF_DEN;
    end else begin
      acc_q <= acc_d;
      num_q <= num_d;
      den_q <= den_d;
    end
  end

endmodule

// File: rtl/pll_clken_gen.sv
// PLL stand-in: lock acquisition FSM, ratio reprogramming handshake and NCH
// fractional clock-enable channels, with a BYPASS override.
module pll_clken_gen
  import pll_pkg::*;
#(
  parameter int unsigned            NCH         = 2,
  parameter int unsigned            ACC_W       = ACC_W_DEF,
  parameter int unsigned            LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter logic [NCH*ACC_W-1:0]   DEF_NUM     = {NCH{ACC_W'(1)}},
  parameter logic [NCH*ACC_W-1:0]   DEF_DEN     = {NCH{ACC_W'(1)}},
  localparam int unsigned           CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             PACKAGEPIN,
  input  logic             RESETB,
  input  logic             BYPASS,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [ACC_W-1:0] cfg_num,
  input  logic [ACC_W-1:0] cfg_den,
  output logic [NCH-1:0]   CLKEN,
  output logic             LOCK
);

  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  pll_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_q, lock_d;
  logic             ready_q, ready_d;
  logic [NCH-1:0]   clken_q, clken_d;
  logic [NCH-1:0]   wr_en_c;
  logic [NCH-1:0]   pulse_c;
  logic             accept_c;
  logic             hit_c;
  logic             run_c;

  // Next state, handshake decode and output muxing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = cfg_valid && ready_q;
    for (int i = 0; i < NCH; i++) begin
      wr_en_c[i] = accept_c && (cfg_ch == CH_W'(i));
    end
    hit_c = |wr_en_c;
    unique case (state_q)
      RESET: begin
        if (!BYPASS) begin
          state_d = LOCKING;
          cnt_d   = '0;
        end
      end
      LOCKING: begin
        if (!BYPASS) begin
          if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) state_d = LOCKED;
          else                                  cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (hit_c) begin
          state_d = LOCKING;
          cnt_d   = '0;
        end
      end
      default: state_d = RESET;
    endcase
    run_c   = (state_q == LOCKED) && !BYPASS && !hit_c;
    lock_d  = BYPASS ? 1'b1 : (state_d == LOCKED);
    clken_d = BYPASS ? '1 : pulse_c;
    ready_d = (state_d == LOCKED) && !BYPASS;
  end

  always_ff @(posedge PACKAGEPIN or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= RESET;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      ready_q <= 1'b0;
      clken_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      ready_q <= ready_d;
      clken_q <= clken_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    frac_clken #(
      .ACC_W  (ACC_W),
      .DEF_NUM(DEF_NUM[g*ACC_W +: ACC_W]),
      .DEF_DEN(DEF_DEN[g*ACC_W +: ACC_W])
    ) u_ch (
      .clk    (PACKAGEPIN),
      .rst_n  (RESETB),
      .wr_en  (wr_en_c[g]),
      .wr_num (cfg_num),
      .wr_den (cfg_den),
      .clr    (hit_c),
      .run    (run_c),
      .pulse_c(pulse_c[g])
    );
  end

  assign CLKEN     = clken_q;
  assign LOCK      = lock_q;
  assign cfg_ready = ready_q;

endmodule

// File: tb/tb_pll_clken_gen.sv
// Randomized bench for pll_clken_gen against a rate/lock-time model of the PLL.
module tb_pll_clken_gen;

  localparam int NCH = 3;
  localparam int LC  = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           bypass = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic [15:0]    cfg_num = '0;
  logic [15:0]    cfg_den = '0;
  logic [NCH-1:0] clken;
  logic           lock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  pll_clken_gen #(.NCH(NCH), .ACC_W(16), .LOCK_CYCLES(LC)) dut (
    .PACKAGEPIN(clk), .RESETB(rst_n), .BYPASS(bypass),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_num(cfg_num), .cfg_den(cfg_den), .CLKEN(clken), .LOCK(lock)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: lock progress counted in edges, pulses from floor(n*num/den) steps.
  bit             m_started = 0, m_locked = 0;
  int             m_cnt = 0;
  longint         m_n = 0;
  int             m_num [NCH] = '{default: 1};
  int             m_den [NCH] = '{default: 1};
  logic [NCH-1:0] m_clken = '0;
  logic           m_lock = 0, m_ready = 0;

  function automatic bit pulse(longint n, longint num, longint den);
    longint nn;
    if (den == 0) return 0;
    nn = (num > den) ? den : num;
    return (n * nn / den) > ((n - 1) * nn / den);
  endfunction

  task model_reset();
    m_started = 0; m_locked = 0; m_cnt = 0; m_n = 0;
    for (int i = 0; i < NCH; i++) begin m_num[i] = 1; m_den[i] = 1; end
    m_clken = '0; m_lock = 0; m_ready = 0;
  endtask

  task model_step();
    int ch;
    ch = int'(cfg_ch);
    if (m_ready && cfg_valid && ch < NCH) begin
      m_num[ch] = int'(cfg_num); m_den[ch] = int'(cfg_den);
      m_locked = 0; m_cnt = 0; m_n = 0;
      m_lock = bypass; m_clken = bypass ? '1 : '0; m_ready = 0;
    end else if (bypass) begin
      m_lock = 1; m_clken = '1; m_ready = 0;
    end else if (!m_started) begin
      m_started = 1; m_cnt = 0; m_lock = 0; m_clken = '0; m_ready = 0;
    end else if (!m_locked) begin
      if (m_cnt == LC - 1) begin
        m_locked = 1; m_n = 0; m_lock = 1; m_ready = 1;
      end else begin
        m_cnt++; m_lock = 0; m_ready = 0;
      end
      m_clken = '0;
    end else begin
      m_n++;
      for (int i = 0; i < NCH; i++) m_clken[i] = pulse(m_n, m_num[i], m_den[i]);
      m_lock = 1; m_ready = 1;
    end
  endtask

  // Compare process: every edge and every asynchronous reset assertion.
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    chk("CLKEN", 32'(clken), 32'(m_clken));
    chk("LOCK", 32'(lock), 32'(m_lock));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
  end

  task automatic cfg_write(input int ch, input int num, input int den, input bit hold,
                           output int acc_cyc);
    bit done;
    done = 0;
    acc_cyc = -1;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_num = 16'(num); cfg_den = 16'(den);
    for (int t = 0; t < 400 && !done; t++) begin
      if (cfg_ready) begin
        @(negedge clk);
        acc_cyc = cyc;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL cfg_timeout: ch %0d not accepted within 400 cycles", ch);
    end
    if (!hold) cfg_valid = 1'b0;
  endtask

  task automatic wait_lock(output int edges);
    bit seen;
    seen = 0;
    edges = 0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(posedge clk); #1;
      edges++;
      if (lock) seen = 1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL lock_timeout: LOCK low after %0d edges", edges);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, a1, a2, cnt0, cnt2;
    logic [7:0] p0, p1, p2;

    // Reset, release, lock time.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    wait_lock(e);
    chk("lock_after_reset", 32'(e), 32'd64);

    // 1/4 and 3/8 patterns on the first locked cycles.
    cfg_write(0, 1, 4, 0, a1);
    wait_lock(e);
    cfg_write(1, 3, 8, 0, a1);
    wait_lock(e);
    chk("relock_edges", 32'(e), 32'd64);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      p0[k] = clken[0]; p1[k] = clken[1]; p2[k] = clken[2];
    end
    chk("pattern_1_4", 32'(p0), 32'h88);
    chk("pattern_3_8", 32'(p1), 32'hA4);
    chk("pattern_default", 32'(p2), 32'hFF);

    // Relock on a real write; out-of-range channel is ignored.
    cfg_write(1, 1, 2, 0, a1);
    chk("lock_drop", 32'(lock), 32'd0);
    wait_lock(e);
    chk("relock_1_2", 32'(e), 32'd64);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      p1[k] = clken[1];
    end
    chk("pattern_1_2", 32'(p1[3:0]), 32'hA);
    cfg_write(3, 5, 5, 0, a1);
    chk("ignored_ch_lock", 32'(lock), 32'd1);

    // Clamped numerator and zero denominator.
    cfg_write(2, 9, 4, 0, a1);
    wait_lock(e);
    cfg_write(0, 5, 0, 0, a1);
    wait_lock(e);
    cnt0 = 0; cnt2 = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      cnt0 += int'(clken[0]); cnt2 += int'(clken[2]);
    end
    chk("den_zero_pulses", 32'(cnt0), 32'd0);
    chk("clamped_pulses", 32'(cnt2), 32'd16);

    // Request held across LOCKING is taken on the first locked edge.
    cfg_write(0, 1, 3, 1, a1);
    cfg_write(1, 2, 5, 0, a2);
    chk("held_request_delay", 32'(a2 - a1), 32'd65);

    // BYPASS at lock counter 30 freezes the count.
    cfg_write(2, 1, 1, 0, a1);
    repeat (30) @(negedge clk);
    bypass = 1'b1;
    repeat (5) @(negedge clk);
    chk("bypass_clken", 32'(clken), 32'h7);
    chk("bypass_lock", 32'(lock), 32'd1);
    bypass = 1'b0;
    @(posedge clk); #1;
    chk("lock_after_bypass", 32'(lock), 32'd0);
    wait_lock(e);
    chk("resume_edges", 32'(e + 1), 32'd34);

    // Randomized ratio writes, bypass pulses and idle stretches.
    for (int it = 0; it < 30; it++) begin
      int op, ch;
      op = int'($urandom_range(0, 3));
      ch = int'($urandom_range(0, 3));
      case (op)
        0: begin
          cfg_write(ch, int'($urandom_range(0, 10)), int'($urandom_range(0, 10)), 0, a1);
          if (ch < NCH) wait_lock(e);
          repeat (int'($urandom_range(5, 40))) @(negedge clk);
        end
        1: cfg_write(ch, int'($urandom_range(0, 12)), int'($urandom_range(1, 12)), 0, a1);
        2: begin
          @(negedge clk);
          bypass = 1'b1;
          repeat (int'($urandom_range(1, 6))) @(negedge clk);
          bypass = 1'b0;
        end
        default: repeat (int'($urandom_range(1, 30))) @(negedge clk);
      endcase
    end

    // Asynchronous reset between edges while locked.
    wait_lock(e);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_lock", 32'(lock), 32'd0);
    chk("async_rst_clken", 32'(clken), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    wait_lock(e);
    chk("lock_after_async_rst", 32'(e), 32'd64);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
